// File: rtl/writeback_queue_if.sv
// Result-channel and register-file write-port bundle for writeback_queue.
// The master side produces results and consumes the Decode write port.
interface writeback_queue_if #(
    parameter int QDEPTH = 4,
    parameter int REG_W  = 32,
    parameter int RIDX_W = 4,
    parameter int CNT_W  = 32
);
    localparam int QCW = $clog2(QDEPTH + 1);

    logic              I_AluValid;
    logic [RIDX_W-1:0] I_AluRegIdx;
    logic [REG_W-1:0]  I_AluData;
    logic              I_LdValid;
    logic [RIDX_W-1:0] I_LdRegIdx;
    logic [REG_W-1:0]  I_LdData;

    logic              O_Ready;
    logic              O_WriteBackEnable;
    logic [RIDX_W-1:0] O_WriteBackRegIdx;
    logic [REG_W-1:0]  O_WriteBackData;
    logic [QCW-1:0]    O_QueueCount;
    logic [CNT_W-1:0]  O_RetireCount;
    logic              O_Overflow;
    logic              O_Idle;

    modport master (
        output I_AluValid, I_AluRegIdx, I_AluData,
        output I_LdValid, I_LdRegIdx, I_LdData,
        input  O_Ready, O_WriteBackEnable,
        input  O_WriteBackRegIdx, O_WriteBackData,
        input  O_QueueCount, O_RetireCount,
        input  O_Overflow, O_Idle
    );

    modport slave (
        input  I_AluValid, I_AluRegIdx, I_AluData,
        input  I_LdValid, I_LdRegIdx, I_LdData,
        output O_Ready, O_WriteBackEnable,
        output O_WriteBackRegIdx, O_WriteBackData,
        output O_QueueCount, O_RetireCount,
        output O_Overflow, O_Idle
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback queue merging ALU and load results into one RF write port.
// State moves on the falling clock edge so Decode sees stable values at the rising edge.
module writeback_queue #(
    parameter int QDEPTH = 4,
    parameter int REG_W  = 32,
    parameter int RIDX_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic             I_CLOCK,
    input  logic             I_RESET,
    writeback_queue_if.slave bus
);
    localparam int QCW = $clog2(QDEPTH + 1);
    localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int EW  = RIDX_W + REG_W;

    logic [EW-1:0]     mem_q [QDEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW-1:0]     tail1, tail2;
    logic [QCW-1:0]    count_q, count_d;
    logic              wb_en_q, wb_en_d;
    logic [RIDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [REG_W-1:0]  wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              ovf_q, ovf_d;

    logic              ready;
    logic              head_vld;
    logic              acc_ld;
    logic              acc_alu;
    logic [EW-1:0]     ld_ent;
    logic [EW-1:0]     alu_ent;
    logic [EW-1:0]     push0;
    logic [EW-1:0]     push1;
    logic [1:0]        push_n;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Two free slots are needed: both channels may land while only one issues.
    assign ready    = (count_q <= QCW'(QDEPTH - 2));
    assign head_vld = (count_q != '0);
    assign acc_ld   = bus.I_LdValid & ready;
    assign acc_alu  = bus.I_AluValid & ready;
    assign ld_ent   = {bus.I_LdRegIdx, bus.I_LdData};
    assign alu_ent  = {bus.I_AluRegIdx, bus.I_AluData};
    assign tail1    = ptr_inc(tail_q);
    assign tail2    = ptr_inc(tail1);

    always_comb begin
        wb_en_d   = 1'b0;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        head_d    = head_q;
        push_n    = 2'd0;
        push0     = '0;
        push1     = '0;
        unique case (1'b1)
            head_vld: begin
                wb_en_d               = 1'b1;
                {wb_idx_d, wb_data_d} = mem_q[head_q];
                head_d                = ptr_inc(head_q);
                if (acc_ld) begin
                    push0  = ld_ent;
                    push1  = alu_ent;
                    push_n = acc_alu ? 2'd2 : 2'd1;
                end else if (acc_alu) begin
                    push0  = alu_ent;
                    push_n = 2'd1;
                end
            end
            (!head_vld && acc_ld): begin
                wb_en_d               = 1'b1;
                {wb_idx_d, wb_data_d} = ld_ent;
                if (acc_alu) begin
                    push0  = alu_ent;
                    push_n = 2'd1;
                end
            end
            (!head_vld && !acc_ld && acc_alu): begin
                wb_en_d               = 1'b1;
                {wb_idx_d, wb_data_d} = alu_ent;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        tail_d = tail_q;
        unique case (push_n)
            2'd1:    tail_d = tail1;
            2'd2:    tail_d = tail2;
            default: tail_d = tail_q;
        endcase
    end

    assign count_d = count_q + QCW'(acc_ld) + QCW'(acc_alu)
                   - QCW'(wb_en_d);
    assign retire_d = retire_q + CNT_W'(wb_en_d);
    // Dropped results are remembered until reset.
    assign ovf_d = ovf_q
                 | ((bus.I_LdValid | bus.I_AluValid) & ~ready);

    always_ff @(negedge I_CLOCK) begin
        if (push_n != 2'd0) begin
            mem_q[tail_q] <= push0;
        end
        if (push_n == 2'd2) begin
            mem_q[tail1] <= push1;
        end
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
            retire_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wb_en_q   <= wb_en_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            retire_q  <= retire_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.O_Ready           = ready;
    assign bus.O_WriteBackEnable = wb_en_q;
    assign bus.O_WriteBackRegIdx = wb_idx_q;
    assign bus.O_WriteBackData   = wb_data_q;
    assign bus.O_QueueCount      = count_q;
    assign bus.O_RetireCount     = retire_q;
    assign bus.O_Overflow        = ovf_q;
    assign bus.O_Idle            = (count_q == '0) && !wb_en_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with QDEPTH=4 and a 4-bit retire counter.
// Expected write order is hand-built from the arrival order of results.
module tb_writeback_queue;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [3:0] exp_ret;

    writeback_queue_if #(.QDEPTH(4), .REG_W(32), .RIDX_W(4), .CNT_W(4)) bus ();

    writeback_queue #(
        .QDEPTH(4), .REG_W(32), .RIDX_W(4), .CNT_W(4)
    ) dut (
        .I_CLOCK(clk),
        .I_RESET(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [3:0] li, input logic [31:0] ld,
                         input logic av, input logic [3:0] ai, input logic [31:0] ad);
        bus.I_LdValid   = lv;
        bus.I_LdRegIdx  = li;
        bus.I_LdData    = ld;
        bus.I_AluValid  = av;
        bus.I_AluRegIdx = ai;
        bus.I_AluData   = ad;
    endtask

    task automatic idle_in();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        repeat (2) cyc();
        exp_ret = 4'd0;
        n_chk++; if (bus.O_WriteBackEnable !== 1'b0) begin n_fail++;
            $display("FAIL reset_en: got %0b want 0", bus.O_WriteBackEnable); end
        n_chk++; if (bus.O_WriteBackRegIdx !== 4'd0) begin n_fail++;
            $display("FAIL reset_idx: got %0d want 0", bus.O_WriteBackRegIdx); end
        n_chk++; if (bus.O_WriteBackData !== 32'd0) begin n_fail++;
            $display("FAIL reset_data: got %h want 0", bus.O_WriteBackData); end
        n_chk++; if (bus.O_RetireCount !== 4'd0) begin n_fail++;
            $display("FAIL reset_ret: got %0d want 0", bus.O_RetireCount); end
        n_chk++; if (bus.O_Overflow !== 1'b0) begin n_fail++;
            $display("FAIL reset_ovf: got %0b want 0", bus.O_Overflow); end
        n_chk++; if (bus.O_QueueCount !== 3'd0) begin n_fail++;
            $display("FAIL reset_qc: got %0d want 0", bus.O_QueueCount); end
        n_chk++; if (bus.O_Ready !== 1'b1 || bus.O_Idle !== 1'b1) begin n_fail++;
            $display("FAIL reset_rdy_idle: got %0b%0b want 11", bus.O_Ready, bus.O_Idle); end
        rst = 1'b0;
        cyc();
        n_chk++; if (bus.O_WriteBackEnable !== 1'b0 || bus.O_Idle !== 1'b1) begin n_fail++;
            $display("FAIL reset_release: en=%0b idle=%0b want 0 1",
                     bus.O_WriteBackEnable, bus.O_Idle); end
    endtask

    task automatic test_bypass();
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h0000_0005);
        cyc();
        exp_ret++;
        idle_in();
        n_chk++; if (bus.O_WriteBackEnable !== 1'b1) begin n_fail++;
            $display("FAIL bypass_en: got %0b want 1", bus.O_WriteBackEnable); end
        n_chk++; if (bus.O_WriteBackRegIdx !== 4'd3 || bus.O_WriteBackData !== 32'd5) begin
            n_fail++;
            $display("FAIL bypass_wr: got R%0d=%h want R3=5",
                     bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
        n_chk++; if (bus.O_QueueCount !== 3'd0) begin n_fail++;
            $display("FAIL bypass_qc: got %0d want 0", bus.O_QueueCount); end
        n_chk++; if (bus.O_RetireCount !== exp_ret) begin n_fail++;
            $display("FAIL bypass_ret: got %0d want %0d", bus.O_RetireCount, exp_ret); end
        cyc();
        n_chk++; if (bus.O_WriteBackEnable !== 1'b0 || bus.O_Idle !== 1'b1) begin n_fail++;
            $display("FAIL bypass_one_cycle: en=%0b idle=%0b want 0 1",
                     bus.O_WriteBackEnable, bus.O_Idle); end
        n_chk++; if (bus.O_WriteBackRegIdx !== 4'd3 || bus.O_WriteBackData !== 32'd5) begin
            n_fail++;
            $display("FAIL bypass_hold: got R%0d=%h want R3=5",
                     bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rf2;
        rf2 = 32'd0;
        drive(1'b1, 4'd2, 32'hFFFF_FFFF, 1'b1, 4'd2, 32'h0000_0007);
        cyc();
        exp_ret++;
        idle_in();
        if (bus.O_WriteBackEnable === 1'b1) rf2 = bus.O_WriteBackData;
        n_chk++; if (bus.O_WriteBackEnable !== 1'b1 || bus.O_WriteBackRegIdx !== 4'd2
                     || bus.O_WriteBackData !== 32'hFFFF_FFFF) begin n_fail++;
            $display("FAIL simul_first: got en=%0b R%0d=%h want R2=ffffffff",
                     bus.O_WriteBackEnable, bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
        n_chk++; if (bus.O_QueueCount !== 3'd1) begin n_fail++;
            $display("FAIL simul_qc: got %0d want 1", bus.O_QueueCount); end
        cyc();
        exp_ret++;
        if (bus.O_WriteBackEnable === 1'b1) rf2 = bus.O_WriteBackData;
        n_chk++; if (bus.O_WriteBackEnable !== 1'b1 || bus.O_WriteBackRegIdx !== 4'd2
                     || bus.O_WriteBackData !== 32'h7) begin n_fail++;
            $display("FAIL simul_second: got en=%0b R%0d=%h want R2=7",
                     bus.O_WriteBackEnable, bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
        cyc();
        n_chk++; if (rf2 !== 32'h7 || bus.O_Idle !== 1'b1) begin n_fail++;
            $display("FAIL simul_rf2: got rf2=%h idle=%0b want 7 1", rf2, bus.O_Idle); end
        n_chk++; if (bus.O_RetireCount !== exp_ret) begin n_fail++;
            $display("FAIL simul_ret: got %0d want %0d", bus.O_RetireCount, exp_ret); end
    endtask

    task automatic test_fill();
        logic [3:0]  ei [6];
        logic [31:0] ed [6];
        for (int k = 0; k < 3; k++) begin
            ei[2*k]   = 4'(k + 4);
            ed[2*k]   = 32'hA0 + 32'(k);
            ei[2*k+1] = 4'(k + 8);
            ed[2*k+1] = 32'hB0 + 32'(k);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, ei[2*c], ed[2*c], 1'b1, ei[2*c+1], ed[2*c+1]);
            cyc();
            exp_ret++;
            idle_in();
            n_chk++; if (bus.O_WriteBackEnable !== 1'b1 || bus.O_WriteBackRegIdx !== ei[c]
                         || bus.O_WriteBackData !== ed[c]) begin n_fail++;
                $display("FAIL fill_wr%0d: got en=%0b R%0d=%h want R%0d=%h", c,
                         bus.O_WriteBackEnable, bus.O_WriteBackRegIdx,
                         bus.O_WriteBackData, ei[c], ed[c]); end
            n_chk++; if (bus.O_QueueCount !== 3'(c + 1)
                         || bus.O_Ready !== (c + 1 <= 2)) begin n_fail++;
                $display("FAIL fill_qc%0d: got qc=%0d rdy=%0b want %0d %0b", c,
                         bus.O_QueueCount, bus.O_Ready, c + 1, (c + 1 <= 2)); end
        end
        for (int d = 0; d < 3; d++) begin
            cyc();
            exp_ret++;
            n_chk++; if (bus.O_WriteBackEnable !== 1'b1 || bus.O_WriteBackRegIdx !== ei[3+d]
                         || bus.O_WriteBackData !== ed[3+d]) begin n_fail++;
                $display("FAIL drain_wr%0d: got en=%0b R%0d=%h want R%0d=%h", d,
                         bus.O_WriteBackEnable, bus.O_WriteBackRegIdx,
                         bus.O_WriteBackData, ei[3+d], ed[3+d]); end
            n_chk++; if (bus.O_QueueCount !== 3'(2 - d)) begin n_fail++;
                $display("FAIL drain_qc%0d: got %0d want %0d", d, bus.O_QueueCount, 2 - d); end
        end
        cyc();
        n_chk++; if (bus.O_WriteBackEnable !== 1'b0 || bus.O_Idle !== 1'b1
                     || bus.O_Overflow !== 1'b0) begin n_fail++;
            $display("FAIL fill_end: en=%0b idle=%0b ovf=%0b want 0 1 0",
                     bus.O_WriteBackEnable, bus.O_Idle, bus.O_Overflow); end
        n_chk++; if (bus.O_RetireCount !== exp_ret) begin n_fail++;
            $display("FAIL fill_ret: got %0d want %0d", bus.O_RetireCount, exp_ret); end
    endtask

    task automatic fill3(input logic [31:0] base);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'(2*c), base + 32'(2*c), 1'b1, 4'(2*c+1), base + 32'(2*c+1));
            cyc();
            exp_ret++;
        end
        idle_in();
    endtask

    task automatic test_overflow();
        fill3(32'hC0);
        n_chk++; if (bus.O_QueueCount !== 3'd3 || bus.O_Ready !== 1'b0) begin n_fail++;
            $display("FAIL ovf_pre: qc=%0d rdy=%0b want 3 0", bus.O_QueueCount, bus.O_Ready); end
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'hDEAD);
        cyc();
        exp_ret++;
        idle_in();
        n_chk++; if (bus.O_Overflow !== 1'b1) begin n_fail++;
            $display("FAIL ovf_set: got %0b want 1", bus.O_Overflow); end
        n_chk++; if (bus.O_QueueCount !== 3'd2) begin n_fail++;
            $display("FAIL ovf_qc: got %0d want 2", bus.O_QueueCount); end
        n_chk++; if (bus.O_WriteBackRegIdx !== 4'd3 || bus.O_WriteBackData !== 32'hC3) begin
            n_fail++;
            $display("FAIL ovf_wr: got R%0d=%h want R3=c3",
                     bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
        repeat (2) begin cyc(); exp_ret++; end
        n_chk++; if (bus.O_WriteBackRegIdx !== 4'd5 || bus.O_WriteBackData !== 32'hC5) begin
            n_fail++;
            $display("FAIL ovf_last: got R%0d=%h want R5=c5",
                     bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
        cyc();
        n_chk++; if (bus.O_WriteBackEnable !== 1'b0 || bus.O_WriteBackData === 32'hDEAD) begin
            n_fail++;
            $display("FAIL ovf_dropped: en=%0b data=%h want 0 not dead",
                     bus.O_WriteBackEnable, bus.O_WriteBackData); end
        n_chk++; if (bus.O_Overflow !== 1'b1 || bus.O_RetireCount !== exp_ret) begin n_fail++;
            $display("FAIL ovf_sticky: ovf=%0b ret=%0d want 1 %0d",
                     bus.O_Overflow, bus.O_RetireCount, exp_ret); end
    endtask

    task automatic test_reset_mid();
        fill3(32'hE0);
        n_chk++; if (bus.O_QueueCount !== 3'd3) begin n_fail++;
            $display("FAIL rmid_pre: qc=%0d want 3", bus.O_QueueCount); end
        #2;
        rst = 1'b1;
        #1;
        exp_ret = 4'd0;
        n_chk++; if (bus.O_WriteBackEnable !== 1'b0 || bus.O_WriteBackRegIdx !== 4'd0
                     || bus.O_WriteBackData !== 32'd0) begin n_fail++;
            $display("FAIL rmid_wr: en=%0b R%0d=%h want 0 0 0", bus.O_WriteBackEnable,
                     bus.O_WriteBackRegIdx, bus.O_WriteBackData); end
        n_chk++; if (bus.O_QueueCount !== 3'd0 || bus.O_RetireCount !== 4'd0
                     || bus.O_Overflow !== 1'b0) begin n_fail++;
            $display("FAIL rmid_state: qc=%0d ret=%0d ovf=%0b want 0 0 0",
                     bus.O_QueueCount, bus.O_RetireCount, bus.O_Overflow); end
        n_chk++; if (bus.O_Ready !== 1'b1 || bus.O_Idle !== 1'b1) begin n_fail++;
            $display("FAIL rmid_rdy: rdy=%0b idle=%0b want 1 1", bus.O_Ready, bus.O_Idle); end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++; if (bus.O_WriteBackEnable !== 1'b0 || bus.O_QueueCount !== 3'd0
                         || bus.O_RetireCount !== 4'd0) begin n_fail++;
                $display("FAIL rmid_stale%0d: en=%0b qc=%0d ret=%0d want 0 0 0", i,
                         bus.O_WriteBackEnable, bus.O_QueueCount, bus.O_RetireCount); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  ai [20];
        logic [31:0] ad [20];
        int sent;
        int got;
        int extra;
        sent  = 0;
        got   = 0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            ai[i] = 4'(i);
            ad[i] = 32'h1000 + 32'(i);
        end
        for (int t = 0; t < 60; t++) begin
            if (bus.O_Ready === 1'b1 && sent < 20) begin
                drive(1'b1, ai[sent], ad[sent], 1'b1, ai[sent+1], ad[sent+1]);
                sent += 2;
            end else begin
                idle_in();
            end
            cyc();
            if (bus.O_WriteBackEnable === 1'b1) begin
                if (got < 20) begin
                    exp_ret++;
                    n_chk++; if (bus.O_WriteBackRegIdx !== ai[got]
                                 || bus.O_WriteBackData !== ad[got]) begin n_fail++;
                        $display("FAIL wrap_wr%0d: got R%0d=%h want R%0d=%h", got,
                                 bus.O_WriteBackRegIdx, bus.O_WriteBackData, ai[got], ad[got]); end
                    n_chk++; if (bus.O_RetireCount !== exp_ret) begin n_fail++;
                        $display("FAIL wrap_ret%0d: got %0d want %0d", got,
                                 bus.O_RetireCount, exp_ret); end
                    got++;
                end else begin
                    extra++;
                end
            end
        end
        idle_in();
        n_chk++; if (got != 20 || extra != 0) begin n_fail++;
            $display("FAIL wrap_total: got %0d writes (+%0d extra) want 20", got, extra); end
        n_chk++; if (bus.O_RetireCount !== 4'd4 || bus.O_Idle !== 1'b1
                     || bus.O_Overflow !== 1'b0) begin n_fail++;
            $display("FAIL wrap_end: ret=%0d idle=%0b ovf=%0b want 4 1 0",
                     bus.O_RetireCount, bus.O_Idle, bus.O_Overflow); end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        exp_ret = 4'd0;
        test_reset();
        test_bypass();
        test_simultaneous();
        test_fill();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
